// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequenced one nibble per clock through a single shared 4-bit adder.
// The inter-nibble carry is held in a register, so an operation takes WORDS cycles in RUN.

module four_bit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module nibble_serial_add_ctrl #(
   parameter int WORDS = 4,
   localparam int W    = 4 * WORDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         sub,
   input  logic         cin,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf,
   output logic         busy
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [WORDS-1:0][3:0]   a_q, b_q, res_q;
   logic [IW-1:0]           idx_q;
   logic                    carry_q;
   logic                    cout_q, ovf_q;
   logic [3:0]              a_nib, b_nib, sum;
   logic                    c4;
   logic                    last;
   logic                    accept;

   assign accept = (state == IDLE) && start_valid;
   assign last   = (idx_q == IW'(WORDS - 1));
   assign a_nib  = a_q[idx_q];
   assign b_nib  = b_q[idx_q];

   four_bit_adder u_add (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry_q),
      .s  (sum),
      .co (c4)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_valid) state_nxt = RUN;
         RUN:     if (last)        state_nxt = DONE;
         DONE:    if (res_ready)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Outputs decoded purely from state
   always_comb begin
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
         end
         DONE:    res_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: subtraction is A + ~B + 1, so B is inverted at load and carry seeded with 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= op_a;
         b_q     <= sub ? ~op_b : op_b;
         carry_q <= sub ? 1'b1 : cin;
         idx_q   <= '0;
      end else if (state == RUN) begin
         res_q[idx_q] <= sum;
         carry_q      <= c4;
         idx_q        <= idx_q + 1'b1;
         if (last) begin
            cout_q <= c4;
            ovf_q  <= (a_nib[3] == b_nib[3]) && (sum[3] != a_nib[3]);
         end
      end
   end

   assign result = res_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 16-bit instance checked against a
// scoreboard of arithmetic reference results, plus a 4-bit (WORDS=1) instance.

module tb_nibble_serial_add_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid, start_ready, sub, cin;
   logic [15:0] op_a, op_b, result;
   logic        res_valid, res_ready, cout, ovf, busy;

   logic        w1_start_valid, w1_start_ready, w1_sub, w1_cin;
   logic [3:0]  w1_op_a, w1_op_b, w1_result;
   logic        w1_res_valid, w1_res_ready, w1_cout, w1_ovf, w1_busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   nibble_serial_add_ctrl #(.WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin), .res_valid(res_valid),
      .res_ready(res_ready), .result(result), .cout(cout), .ovf(ovf), .busy(busy)
   );

   nibble_serial_add_ctrl #(.WORDS(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .start_valid(w1_start_valid), .start_ready(w1_start_ready),
      .op_a(w1_op_a), .op_b(w1_op_b), .sub(w1_sub), .cin(w1_cin), .res_valid(w1_res_valid),
      .res_ready(w1_res_ready), .result(w1_result), .cout(w1_cout), .ovf(w1_ovf), .busy(w1_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, b, input logic s, c);
      logic [16:0] full;
      logic [15:0] bb;
      exp_t e;
      bb     = s ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : c);
      e.res  = full[15:0];
      e.cout = full[16];
      e.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
      return e;
   endfunction

   // Presents one command for a single cycle; returns just after the accept edge
   task automatic issue(input logic [15:0] a, b, input logic s, c);
      @(negedge clk);
      chk("start_ready_before_accept", start_ready, 1'b1);
      op_a = a; op_b = b; sub = s; cin = c; start_valid = 1'b1;
      sb.push_back(model(a, b, s, c));
      @(posedge clk);
      #1 start_valid = 1'b0;
      op_a = 16'hxxxx; op_b = 16'hxxxx;
   endtask

   // Waits for res_valid, reporting cycles since accept and negedges with busy high
   task automatic wait_result(output int cyc, output int nbusy);
      cyc = 0; nbusy = 0;
      while (cyc < 20) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (res_valid) break;
         @(posedge clk);
         cyc++;
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_cout"}, cout, e.cout);
      chk({tag, "_ovf"}, ovf, e.ovf);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, b, input logic s, c);
      int cyc, nb;
      issue(a, b, s, c);
      wait_result(cyc, nb);
      chk({tag, "_latency"}, cyc, 4);
      chk({tag, "_busy_cycles"}, nb, 5);
      pop_check(tag);
      @(negedge clk);
      chk({tag, "_idle_ready"}, start_ready, 1'b1);
      chk({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   initial begin
      int   cyc, nb;
      exp_t held;
      rst_n = 1'b0;
      start_valid = 1'b0; res_ready = 1'b1; sub = 1'b0; cin = 1'b0;
      op_a = '0; op_b = '0;
      w1_start_valid = 1'b0; w1_res_ready = 1'b1; w1_sub = 1'b0; w1_cin = 1'b0;
      w1_op_a = '0; w1_op_b = '0;
      #12;
      chk("rst_start_ready", start_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_result", result, 16'h0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      run_op("add_basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
      run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op("add_ovf",   16'h7FFF, 16'h0000, 1'b0, 1'b1);
      run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0);
      run_op("sub_borrow",16'h0003, 16'h0005, 1'b1, 1'b1);

      // Backpressure: hold DONE, poke a command that must be ignored
      res_ready = 1'b0;
      issue(16'h4321, 16'h1111, 1'b0, 1'b0);
      wait_result(cyc, nb);
      chk("bp_latency", cyc, 4);
      held = sb[0];
      pop_check("bp");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start_valid = (i == 2);
         op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1;
         chk("bp_hold_result", result, held.res);
         chk("bp_hold_cout", cout, held.cout);
         chk("bp_hold_ovf", ovf, held.ovf);
         chk("bp_start_ready", start_ready, 1'b0);
         chk("bp_res_valid", res_valid, 1'b1);
      end
      @(negedge clk);
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", start_ready, 1'b1);
      chk("bp_release_valid", res_valid, 1'b0);
      @(negedge clk);
      chk("bp_no_ghost_busy", busy, 1'b0);
      chk("bp_result_retained", result, held.res);

      // Asynchronous reset two cycles into RUN
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_rst_ready", start_ready, 1'b1);
      chk("midrun_rst_valid", res_valid, 1'b0);
      chk("midrun_rst_busy", busy, 1'b0);
      chk("midrun_rst_result", result, 16'h0);
      void'(sb.pop_front());
      @(negedge clk) rst_n = 1'b1;
      run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0);

      // WORDS=1 instance
      @(negedge clk);
      w1_op_a = 4'h9; w1_op_b = 4'h8; w1_cin = 1'b1; w1_sub = 1'b0; w1_start_valid = 1'b1;
      @(negedge clk);
      w1_start_valid = 1'b0;
      chk("w1_running", w1_res_valid, 1'b0);
      chk("w1_busy", w1_busy, 1'b1);
      @(negedge clk);
      chk("w1_res_valid", w1_res_valid, 1'b1);
      chk("w1_result", w1_result, 4'h2);
      chk("w1_cout", w1_cout, 1'b1);
      chk("w1_ovf", w1_ovf, 1'b1);
      @(negedge clk);
      chk("w1_idle", w1_start_ready, 1'b1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that performs wide add/subtract operations on a single shared 4-bit ripple adder (`four_bit_adder`, instantiated once inside this block). It adds one nibble per clock, least significant first, and keeps the inter-nibble carry in a register. It sits between a requester using a valid/ready command interface and a consumer using a valid/ready result interface. It trades latency (WORDS cycles) for a 4-bit datapath.

## Interface
- WORDS, 4, number of 4-bit nibbles per operand; operand width W = 4*WORDS; legal range ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  command present.
- start_ready  out  1  block can accept a command; high only in IDLE.
- op_a  in  W  operand A, sampled at the accept edge.
- op_b  in  W  operand B, sampled at the accept edge.
- sub  in  1  0: A+B+cin; 1: A−B (cin ignored).
- cin  in  1  carry-in for add.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer accepts the result.
- result  out  W  sum/difference, modulo 2^W.
- cout  out  1  add: unsigned carry out; sub: 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on accept (start_valid & start_ready):
  - load A register ← op_a.
  - load B register ← sub ? ~op_b : op_b.
  - carry register ← sub ? 1 : cin.
  - nibble index ← 0.
- RUN, each cycle:
  - Adder inputs are A[4i+3:4i], B[4i+3:4i] and the carry register (i = index).
  - Edge writes: result[4i+3:4i] ← sum; carry register ← adder c4; index ← index+1.
  - On the edge where index = WORDS−1, also write cout ← c4 and ovf ← (a3 == b3) & (s3 != a3), using the final nibble's MSBs with B already inverted for sub. Then → DONE.
- DONE: res_valid = 1. On res_valid & res_ready → IDLE.
- start_valid outside IDLE is ignored; no queuing. op_a, op_b, sub and cin need only be stable at the accept edge.
- result, cout and ovf are stable throughout DONE and retain their values in IDLE until the next accept. Nibbles of result are overwritten progressively during RUN, and consumers must sample only when res_valid is high.
- WORDS = 1: RUN lasts exactly one cycle.
- Reset, asynchronous, any state:
  - State → IDLE; index, carry, A and B → 0.
  - result → 0, cout → 0, ovf → 0.
  - start_ready = 1 while in IDLE after reset; res_valid = 0; busy = 0.
  - Reset mid-RUN aborts the operation; no result is produced.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Reset values: start_ready 1, res_valid 0, busy 0, result 0, cout 0, ovf 0.
- Latency: accept at edge E0; res_valid is high after edge E(WORDS).
- Result handshake at edge Ek → IDLE, so start_ready is high after Ek.
- The earliest next accept is edge Ek+1. Minimum period per operation is WORDS+2 cycles with res_ready tied high.
- res_ready low holds DONE indefinitely with all outputs frozen.

## Test plan
- WORDS=4, add 0x1234 + 0x0FCD, cin=0 → result 0x2201, cout 0, ovf 0. res_valid rises exactly 4 cycles after accept; busy high for 5 cycles with res_ready=1.
- WORDS=4, add 0xFFFF + 0x0001, cin=0 → result 0x0000, cout 1, ovf 0. Then 0x7FFF + 0x0000, cin=1 → 0x8000, cout 0, ovf 1.
- WORDS=4, sub 0x8000 − 0x0001 → result 0x7FFF, cout 1, ovf 1. Then sub 0x0003 − 0x0005 → 0xFFFE, cout 0, ovf 0.
- Backpressure: hold res_ready=0 for 6 cycles in DONE → result, cout and ovf unchanged; start_ready 0. A start_valid pulse carrying other operands is ignored. Raising res_ready completes the handshake; start_ready goes high the next cycle.
- Reset: assert rst_n=0 asynchronously 2 cycles into RUN → immediately start_ready 1, res_valid 0, busy 0, result 0. After release, add 0x00FF + 0x0001 → 0x0100, cout 0.
- WORDS=1, add 0x9 + 0x8, cin=1 → result 0x2, cout 1, ovf 1; res_valid 1 cycle after accept.
